dc_mem_seq: RTL and testbench
=============================

# dc_mem_seq

Memory-side sequencer and arbiter behind the D-cache and I-cache. Accepts D-cache line misses (with optional dirty eviction), D-cache uncached IO accesses, and I-cache line misses. Serialises them onto a single 128-bit system memory port and returns fill or IO data with one-cycle acknowledge pulses. Sits in the MMU, between the cache miss interfaces and the bus.

## Interface
- C_LINE_W, 128, cache line width in bits; bus data width equals C_LINE_W.
- clk  in  1  single clock, all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- dc_miss  in  1  D-cache line miss request, level, held until dc_miss_ack.
- dc_miss_addr  in  32  line-aligned miss address.
- dc_evict  in  1  dirty victim must be written back; valid only with dc_miss.
- dc_evict_addr  in  32  victim line address.
- dc_evict_data  in  C_LINE_W  victim line data.
- dc_data_fill  out  C_LINE_W  fill line, valid in the dc_miss_ack cycle.
- dc_miss_ack  out  1  one-cycle fill-done pulse.
- io_access  in  1  uncached access request, level, held until io_ack.
- io_rw  in  1  1 = write, 0 = read.
- io_addr  in  32  word-aligned IO address.
- io_wr_data  in  32  IO write data.
- io_rd_data  out  32  IO read data, valid in the io_ack cycle, held afterwards.
- io_ack  out  1  one-cycle IO-done pulse.
- ic_miss  in  1  I-cache line miss request, level, held until ic_miss_ack.
- ic_miss_addr  in  32  line-aligned I-side miss address.
- ic_data_fill  out  C_LINE_W  I-side fill line, valid in the ic_miss_ack cycle.
- ic_miss_ack  out  1  one-cycle I-side fill-done pulse.
- bus_req  out  1  bus transaction request, held until bus_ack.
- bus_rw  out  1  1 = write, 0 = read.
- bus_io  out  1  1 = 32-bit IO transfer in bits [31:0], 0 = full line.
- bus_addr  out  32  transaction address.
- bus_wr_data  out  C_LINE_W  write data; IO writes zero-extended.
- bus_ack  in  1  one-cycle completion pulse from bus.
- bus_rd_data  in  C_LINE_W  read data, valid in the bus_ack cycle.

## Operation
- FSM states: IDLE, EVICT, FILL_D, FILL_I, IO, ACK_D, ACK_I, ACK_IO.
- IDLE grant priority: io_access first, then dc_miss versus ic_miss by a round-robin bit rr (0 = D preferred). rr is set to 1 after a D grant and cleared after an I grant. IO grants leave rr unchanged.
- On grant, latch the request address, IO write data/rw, and the evict address/data. The service uses the latched copies. Request inputs are not re-sampled until IDLE.
- Transitions on D grant:
  - dc_evict=1: go to EVICT, a line write to the latched evict address.
  - dc_evict=0: go to FILL_D.
- EVICT + bus_ack -> FILL_D.
- FILL_D + bus_ack -> ACK_D.
- FILL_I + bus_ack -> ACK_I.
- IO + bus_ack -> ACK_IO.
- Every ACK_* state returns to IDLE.
- In FILL_D, FILL_I and IO, bus_rd_data is registered into a fill buffer on bus_ack. IO captures bits [31:0] into io_rd_data. A write IO ignores the bus read data, and io_rd_data keeps its old value.
- ACK_* states drive the matching ack = 1 for exactly one cycle, with fill data taken from the buffer.
- A request dropped mid-service still completes, and its ack is still pulsed.
- bus_ack outside EVICT, FILL_D, FILL_I or IO is ignored.
- All outputs are registered.
- bus_req, bus_rw, bus_io, bus_addr and bus_wr_data stay stable from assertion until the cycle after bus_ack.

## Timing
- Reset: state = IDLE, rr = 0; all outputs, data buffers and latched registers = 0. Takes effect at the first rising edge with rst_n = 0.
- Reset mid-transaction: bus_req drops at that edge and no ack is issued. The bus must discard the outstanding request.
- Request sampled in IDLE at edge t. bus_req is high from t+1.
- bus_ack may arrive in the first bus_req cycle. For a bus_ack at cycle a, bus_req is low from edge a+1.
- Without eviction: ack is high for the cycle after a, then the FSM is in IDLE one cycle later.
- Minimum latency with a zero-wait bus: request seen at t, ack at t+2.
- With eviction, add (bus latency + 1) cycles. There is no bubble between the EVICT bus_ack and the FILL_D bus_req: bus_req stays high and the address and rw change at the same edge.
- A request still asserted in the ack cycle (requester not yet updated) is not re-granted until the following IDLE cycle. Requesters must drop the request by then.
- Simultaneous io_access, dc_miss and ic_miss: IO is served first, then D/I per rr.

## Test plan
- Reset, then dc_miss at 0x0000_1230 with no evict; bus acks after 3 cycles with data 0xA5…A5 -> one read of 0x0000_1230 (bus_io=0), then a one-cycle dc_miss_ack with dc_data_fill = 0xA5…A5, and all outputs 0 afterwards.
- dc_miss 0x40 with dc_evict at 0x7F0 holding data D -> write of D to 0x7F0, then a read of 0x40 with no bus_req gap, then dc_miss_ack.
- dc_miss and ic_miss held together from reset -> D served first, then I, with no extra idle cycle beyond IDLE. Repeat both -> D first again, since rr toggles per grant.
- io_access read at 0xFFFF_0004 alongside dc_miss -> IO served first with bus_io=1; io_rd_data = bus_rd_data[31:0] on io_ack; the D miss follows.
- IO write 0x1234_5678 -> bus_wr_data = 0x…0000_1234_5678, bus_rw=1; io_ack pulses and io_rd_data keeps its old value.
- rst_n low during FILL_D, before bus_ack -> bus_req is 0 at the next edge, no dc_miss_ack; a later bus_ack is ignored and the next request is served normally.

Source files
------------

// File: rtl/dc_mem_seq.sv
// dc_mem_seq: memory-side sequencer/arbiter behind the D-cache and I-cache.
// Serialises D-cache line misses (with optional dirty write-back), uncached IO
// accesses and I-cache line misses onto one line-wide system bus port, and
// returns fill / IO read data with one-cycle acknowledge pulses.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   dc_miss/_addr         D-side line miss request (level, held until ack)
//   dc_evict/_addr/_data  dirty victim to write back before the D fill
//   dc_data_fill          D fill line, valid with dc_miss_ack
//   dc_miss_ack           one-cycle D fill-done pulse
//   io_access/io_rw/...   uncached 32-bit access request
//   io_rd_data            IO read data, valid with io_ack and held afterwards
//   io_ack                one-cycle IO-done pulse
//   ic_miss/_addr         I-side line miss request
//   ic_data_fill          I fill line, valid with ic_miss_ack
//   ic_miss_ack           one-cycle I fill-done pulse
//   bus_*                 system bus request side; bus_ack/bus_rd_data response
module dc_mem_seq #(
  parameter int unsigned C_LINE_W = 128
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic                dc_miss,
  input  logic [31:0]         dc_miss_addr,
  input  logic                dc_evict,
  input  logic [31:0]         dc_evict_addr,
  input  logic [C_LINE_W-1:0] dc_evict_data,
  output logic [C_LINE_W-1:0] dc_data_fill,
  output logic                dc_miss_ack,

  input  logic                io_access,
  input  logic                io_rw,
  input  logic [31:0]         io_addr,
  input  logic [31:0]         io_wr_data,
  output logic [31:0]         io_rd_data,
  output logic                io_ack,

  input  logic                ic_miss,
  input  logic [31:0]         ic_miss_addr,
  output logic [C_LINE_W-1:0] ic_data_fill,
  output logic                ic_miss_ack,

  output logic                bus_req,
  output logic                bus_rw,
  output logic                bus_io,
  output logic [31:0]         bus_addr,
  output logic [C_LINE_W-1:0] bus_wr_data,
  input  logic                bus_ack,
  input  logic [C_LINE_W-1:0] bus_rd_data
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned IO_W   = 32;

  typedef enum logic [2:0] {
    IDLE,
    EVICT,
    FILL_D,
    FILL_I,
    IO,
    ACK_D,
    ACK_I,
    ACK_IO
  } state_t;

  state_t              state, state_nxt;
  logic                rr, rr_nxt;

  // Request copies taken at grant; the service never looks at live inputs.
  logic [ADDR_W-1:0]   lat_addr, lat_addr_nxt;
  logic                lat_io_rw, lat_io_rw_nxt;
  logic [IO_W-1:0]     lat_io_wdata, lat_io_wdata_nxt;
  logic [ADDR_W-1:0]   lat_ev_addr, lat_ev_addr_nxt;
  logic [C_LINE_W-1:0] lat_ev_data, lat_ev_data_nxt;

  logic                dc_ack_nxt, ic_ack_nxt, io_ack_nxt;
  logic [C_LINE_W-1:0] dc_fill_nxt, ic_fill_nxt;
  logic [IO_W-1:0]     io_rd_nxt;
  logic                bus_req_nxt, bus_rw_nxt, bus_io_nxt;
  logic [ADDR_W-1:0]   bus_addr_nxt;
  logic [C_LINE_W-1:0] bus_wr_data_nxt;

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      rr           <= 1'b0;
      lat_addr     <= '0;
      lat_io_rw    <= 1'b0;
      lat_io_wdata <= '0;
      lat_ev_addr  <= '0;
      lat_ev_data  <= '0;
      dc_miss_ack  <= 1'b0;
      ic_miss_ack  <= 1'b0;
      io_ack       <= 1'b0;
      dc_data_fill <= '0;
      ic_data_fill <= '0;
      io_rd_data   <= '0;
      bus_req      <= 1'b0;
      bus_rw       <= 1'b0;
      bus_io       <= 1'b0;
      bus_addr     <= '0;
      bus_wr_data  <= '0;
    end else begin
      state        <= state_nxt;
      rr           <= rr_nxt;
      lat_addr     <= lat_addr_nxt;
      lat_io_rw    <= lat_io_rw_nxt;
      lat_io_wdata <= lat_io_wdata_nxt;
      lat_ev_addr  <= lat_ev_addr_nxt;
      lat_ev_data  <= lat_ev_data_nxt;
      dc_miss_ack  <= dc_ack_nxt;
      ic_miss_ack  <= ic_ack_nxt;
      io_ack       <= io_ack_nxt;
      dc_data_fill <= dc_fill_nxt;
      ic_data_fill <= ic_fill_nxt;
      io_rd_data   <= io_rd_nxt;
      bus_req      <= bus_req_nxt;
      bus_rw       <= bus_rw_nxt;
      bus_io       <= bus_io_nxt;
      bus_addr     <= bus_addr_nxt;
      bus_wr_data  <= bus_wr_data_nxt;
    end
  end

  // Next state, grant/latch decisions and next values of every output.
  always_comb begin
    state_nxt        = state;
    rr_nxt           = rr;
    lat_addr_nxt     = lat_addr;
    lat_io_rw_nxt    = lat_io_rw;
    lat_io_wdata_nxt = lat_io_wdata;
    lat_ev_addr_nxt  = lat_ev_addr;
    lat_ev_data_nxt  = lat_ev_data;
    dc_ack_nxt       = 1'b0;
    ic_ack_nxt       = 1'b0;
    io_ack_nxt       = 1'b0;
    dc_fill_nxt      = '0;
    ic_fill_nxt      = '0;
    io_rd_nxt        = io_rd_data;
    bus_req_nxt      = 1'b0;
    bus_rw_nxt       = 1'b0;
    bus_io_nxt       = 1'b0;
    bus_addr_nxt     = '0;
    bus_wr_data_nxt  = '0;

    unique case (state)
      IDLE: begin
        if (io_access) begin
          // IO wins outright and does not touch the D/I round-robin bit.
          state_nxt        = IO;
          lat_addr_nxt     = io_addr;
          lat_io_rw_nxt    = io_rw;
          lat_io_wdata_nxt = io_wr_data;
        end else if (dc_miss && (!rr || !ic_miss)) begin
          rr_nxt       = 1'b1;
          lat_addr_nxt = dc_miss_addr;
          if (dc_evict) begin
            state_nxt       = EVICT;
            lat_ev_addr_nxt = dc_evict_addr;
            lat_ev_data_nxt = dc_evict_data;
          end else begin
            state_nxt = FILL_D;
          end
        end else if (ic_miss) begin
          state_nxt    = FILL_I;
          rr_nxt       = 1'b0;
          lat_addr_nxt = ic_miss_addr;
        end
      end
      EVICT: begin
        if (bus_ack) state_nxt = FILL_D;
      end
      FILL_D: begin
        if (bus_ack) begin
          state_nxt   = ACK_D;
          dc_ack_nxt  = 1'b1;
          dc_fill_nxt = bus_rd_data;
        end
      end
      FILL_I: begin
        if (bus_ack) begin
          state_nxt   = ACK_I;
          ic_ack_nxt  = 1'b1;
          ic_fill_nxt = bus_rd_data;
        end
      end
      IO: begin
        if (bus_ack) begin
          state_nxt  = ACK_IO;
          io_ack_nxt = 1'b1;
          if (!lat_io_rw) io_rd_nxt = bus_rd_data[IO_W-1:0];
        end
      end
      ACK_D, ACK_I, ACK_IO: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Bus request follows the state being entered, so the EVICT->FILL_D
    // hand-over keeps bus_req high and only swaps address/direction.
    unique case (state_nxt)
      EVICT: begin
        bus_req_nxt     = 1'b1;
        bus_rw_nxt      = 1'b1;
        bus_addr_nxt    = lat_ev_addr_nxt;
        bus_wr_data_nxt = lat_ev_data_nxt;
      end
      FILL_D, FILL_I: begin
        bus_req_nxt  = 1'b1;
        bus_addr_nxt = lat_addr_nxt;
      end
      IO: begin
        bus_req_nxt  = 1'b1;
        bus_io_nxt   = 1'b1;
        bus_rw_nxt   = lat_io_rw_nxt;
        bus_addr_nxt = lat_addr_nxt;
        if (lat_io_rw_nxt)
          bus_wr_data_nxt = {{(C_LINE_W-IO_W){1'b0}}, lat_io_wdata_nxt};
      end
      default: begin
        bus_req_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_dc_mem_seq.sv
// Self-checking bench for dc_mem_seq: a transaction-level model predicts the
// ordered bus transactions, their timing and the acknowledge/data returns.
module tb_dc_mem_seq;

  localparam int unsigned LW = 128;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          dc_miss = 1'b0;
  logic [31:0]   dc_miss_addr = '0;
  logic          dc_evict = 1'b0;
  logic [31:0]   dc_evict_addr = '0;
  logic [LW-1:0] dc_evict_data = '0;
  logic [LW-1:0] dc_data_fill;
  logic          dc_miss_ack;
  logic          io_access = 1'b0;
  logic          io_rw = 1'b0;
  logic [31:0]   io_addr = '0;
  logic [31:0]   io_wr_data = '0;
  logic [31:0]   io_rd_data;
  logic          io_ack;
  logic          ic_miss = 1'b0;
  logic [31:0]   ic_miss_addr = '0;
  logic [LW-1:0] ic_data_fill;
  logic          ic_miss_ack;
  logic          bus_req;
  logic          bus_rw;
  logic          bus_io;
  logic [31:0]   bus_addr;
  logic [LW-1:0] bus_wr_data;
  logic          bus_ack = 1'b0;
  logic [LW-1:0] bus_rd_data = '0;

  dc_mem_seq #(.C_LINE_W(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .dc_miss(dc_miss), .dc_miss_addr(dc_miss_addr), .dc_evict(dc_evict),
    .dc_evict_addr(dc_evict_addr), .dc_evict_data(dc_evict_data),
    .dc_data_fill(dc_data_fill), .dc_miss_ack(dc_miss_ack),
    .io_access(io_access), .io_rw(io_rw), .io_addr(io_addr),
    .io_wr_data(io_wr_data), .io_rd_data(io_rd_data), .io_ack(io_ack),
    .ic_miss(ic_miss), .ic_miss_addr(ic_miss_addr),
    .ic_data_fill(ic_data_fill), .ic_miss_ack(ic_miss_ack),
    .bus_req(bus_req), .bus_rw(bus_rw), .bus_io(bus_io), .bus_addr(bus_addr),
    .bus_wr_data(bus_wr_data), .bus_ack(bus_ack), .bus_rd_data(bus_rd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [LW-1:0] JUNK = {4{32'hDEADBEEF}};

  typedef struct {
    int            kind;   // 0 = D, 1 = I, 2 = IO
    logic          rw;
    logic          io;
    logic [31:0]   addr;
    logic [LW-1:0] wdata;
    logic [LW-1:0] rdata;
    logic          last;
  } txn_t;

  // Model state
  txn_t          exp_q[$];
  bit            m_rr = 1'b0;
  logic [31:0]   m_io_rd = '0;
  bit            pend_d = 0, pend_i = 0, pend_io = 0, pend_io_rd = 0;
  logic [LW-1:0] pend_d_data = '0, pend_i_data = '0;
  logic [31:0]   pend_io_data = '0;
  int            next_req_cyc = 0;
  int            busy = 0;
  int            wait_cfg = 0;

  // Request parameters for the next scenario
  logic [31:0]   r_dc_addr, r_ev_addr, r_ic_addr, r_io_addr, r_io_wdata, r_io_rdata;
  logic          r_ev, r_io_rw;
  logic [LW-1:0] r_ev_data, r_d_fill, r_i_fill;

  // Observations for literal checks
  logic [31:0]   obs_addr[$];
  logic [LW-1:0] obs_wdata[$];
  logic [LW-1:0] cap_d_fill = '0;
  logic [31:0]   cap_io_rd = '0;
  int            d_ack_cyc = 0, i_ack_cyc = 0, io_ack_cyc = 0, ack_count = 0;
  int            n_raise = 0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] obs_a(input int i);
    return (i < obs_addr.size()) ? obs_addr[i] : 32'hxxxx_xxxx;
  endfunction

  function automatic logic [LW-1:0] obs_w(input int i);
    return (i < obs_wdata.size()) ? obs_wdata[i] : {LW{1'bx}};
  endfunction

  // Arbitration order from the grant rules: IO first, then D/I by rr.
  task automatic plan(input bit want_io, input bit want_d, input bit want_i);
    bit pio = want_io, pd = want_d, pi = want_i;
    txn_t t;
    while (pio || pd || pi) begin
      if (pio) begin
        t.kind = 2; t.rw = r_io_rw; t.io = 1'b1; t.addr = r_io_addr;
        t.wdata = {96'b0, r_io_wdata};
        t.rdata = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333, r_io_rdata};
        t.last = 1'b1;
        exp_q.push_back(t);
        pio = 0;
      end else if (pd && (!m_rr || !pi)) begin
        if (r_ev) begin
          t.kind = 0; t.rw = 1'b1; t.io = 1'b0; t.addr = r_ev_addr;
          t.wdata = r_ev_data; t.rdata = JUNK; t.last = 1'b0;
          exp_q.push_back(t);
        end
        t.kind = 0; t.rw = 1'b0; t.io = 1'b0; t.addr = r_dc_addr;
        t.wdata = '0; t.rdata = r_d_fill; t.last = 1'b1;
        exp_q.push_back(t);
        m_rr = 1'b1;
        pd = 0;
      end else begin
        t.kind = 1; t.rw = 1'b0; t.io = 1'b0; t.addr = r_ic_addr;
        t.wdata = '0; t.rdata = r_i_fill; t.last = 1'b1;
        exp_q.push_back(t);
        m_rr = 1'b0;
        pi = 0;
      end
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_rr = 1'b0; m_io_rd = '0;
    pend_d = 0; pend_i = 0; pend_io = 0; pend_io_rd = 0;
    busy = 0; bus_ack = 1'b0; bus_rd_data = JUNK;
  endtask

  // Per-cycle compare against the model, plus requester and bus responder.
  task automatic monitor();
    bit exp_req;
    exp_req = (exp_q.size() != 0) && (cyc >= next_req_cyc);
    chk("bus_req", LW'(bus_req), LW'(exp_req));
    if (bus_req && exp_q.size() != 0) begin
      chk("bus_rw", LW'(bus_rw), LW'(exp_q[0].rw));
      chk("bus_io", LW'(bus_io), LW'(exp_q[0].io));
      chk("bus_addr", LW'(bus_addr), LW'(exp_q[0].addr));
      if (exp_q[0].rw) chk("bus_wr_data", bus_wr_data, exp_q[0].wdata);
    end else if (!bus_req) begin
      chk("bus_idle_ctl", LW'({bus_rw, bus_io, bus_addr}), '0);
      chk("bus_idle_wdata", bus_wr_data, '0);
    end

    if (pend_io && pend_io_rd) m_io_rd = pend_io_data;
    chk("dc_miss_ack", LW'(dc_miss_ack), LW'(pend_d));
    chk("dc_data_fill", dc_data_fill, pend_d ? pend_d_data : '0);
    chk("ic_miss_ack", LW'(ic_miss_ack), LW'(pend_i));
    chk("ic_data_fill", ic_data_fill, pend_i ? pend_i_data : '0);
    chk("io_ack", LW'(io_ack), LW'(pend_io));
    chk("io_rd_data", LW'(io_rd_data), LW'(m_io_rd));
    pend_d = 0; pend_i = 0; pend_io = 0; pend_io_rd = 0;

    if (dc_miss_ack === 1'b1) begin
      cap_d_fill = dc_data_fill; d_ack_cyc = cyc; ack_count++;
      dc_miss = 1'b0; dc_evict = 1'b0;
    end
    if (ic_miss_ack === 1'b1) begin
      i_ack_cyc = cyc; ack_count++; ic_miss = 1'b0;
    end
    if (io_ack === 1'b1) begin
      cap_io_rd = io_rd_data; io_ack_cyc = cyc; ack_count++; io_access = 1'b0;
    end

    if (bus_req && exp_q.size() != 0 && busy >= wait_cfg) begin
      bus_ack = 1'b1;
      bus_rd_data = exp_q[0].rdata;
      obs_addr.push_back(bus_addr);
      obs_wdata.push_back(bus_wr_data);
      if (exp_q[0].last) begin
        case (exp_q[0].kind)
          0: begin pend_d = 1; pend_d_data = exp_q[0].rdata; end
          1: begin pend_i = 1; pend_i_data = exp_q[0].rdata; end
          default: begin
            pend_io = 1; pend_io_rd = !exp_q[0].rw; pend_io_data = exp_q[0].rdata[31:0];
          end
        endcase
        next_req_cyc = cyc + 3;
      end else begin
        next_req_cyc = cyc + 1;
      end
      void'(exp_q.pop_front());
      busy = 0;
    end else begin
      bus_ack = 1'b0;
      bus_rd_data = JUNK;
      busy = bus_req ? busy + 1 : 0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    dc_miss = 1'b0; ic_miss = 1'b0; io_access = 1'b0; dc_evict = 1'b0;
    model_reset();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic raise(input bit want_io, input bit want_d, input bit want_i);
    obs_addr.delete(); obs_wdata.delete();
    plan(want_io, want_d, want_i);
    if (want_d) begin
      dc_miss = 1'b1; dc_miss_addr = r_dc_addr; dc_evict = r_ev;
      dc_evict_addr = r_ev_addr; dc_evict_data = r_ev_data;
    end
    if (want_i) begin
      ic_miss = 1'b1; ic_miss_addr = r_ic_addr;
    end
    if (want_io) begin
      io_access = 1'b1; io_rw = r_io_rw; io_addr = r_io_addr; io_wr_data = r_io_wdata;
    end
    n_raise = cyc;
    next_req_cyc = cyc + 1;
    busy = 0;
  endtask

  task automatic run(input int max_cycles);
    int k = 0;
    while ((exp_q.size() != 0 || pend_d || pend_i || pend_io) && k < max_cycles) begin
      tick();
      k++;
    end
    if (k >= max_cycles) begin
      checks++; errors++;
      $display("FAIL timeout: %0d transactions still outstanding after %0d cycles", exp_q.size(), k);
      do_reset();
    end
    tick();
  endtask

  initial begin
    int acks0;
    r_dc_addr = '0; r_ev_addr = '0; r_ic_addr = '0; r_io_addr = '0;
    r_io_wdata = '0; r_io_rdata = '0; r_ev = 1'b0; r_io_rw = 1'b0;
    r_ev_data = '0; r_d_fill = '0; r_i_fill = '0;
    bus_rd_data = JUNK;

    rst_n = 1'b0;
    tick(); tick();
    chk("reset_outputs", LW'({bus_req, dc_miss_ack, ic_miss_ack, io_ack, io_rd_data}), '0);
    rst_n = 1'b1;
    tick();

    // D miss, no evict, bus answers in its third cycle
    wait_cfg = 2; r_dc_addr = 32'h0000_1230; r_ev = 1'b0; r_d_fill = {4{32'hA5A5A5A5}};
    raise(0, 1, 0);
    run(40);
    chk("t1_ack_latency", LW'(d_ack_cyc - n_raise), LW'(4));
    chk("t1_fill", cap_d_fill, {4{32'hA5A5A5A5}});
    chk("t1_addr", LW'(obs_a(0)), LW'(32'h0000_1230));

    // Zero-wait bus: minimum latency
    wait_cfg = 0; r_dc_addr = 32'h0000_2000; r_d_fill = {4{32'h0F0F_1234}};
    raise(0, 1, 0);
    run(40);
    chk("t1b_min_latency", LW'(d_ack_cyc - n_raise), LW'(2));

    // D miss with dirty eviction: write-back then fill, no bus_req gap
    wait_cfg = 1; r_dc_addr = 32'h0000_0040; r_ev = 1'b1; r_ev_addr = 32'h0000_07F0;
    r_ev_data = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210; r_d_fill = {4{32'h5A5A_0001}};
    raise(0, 1, 0);
    run(40);
    chk("t2_ack_latency", LW'(d_ack_cyc - n_raise), LW'(5));
    chk("t2_evict_addr", LW'(obs_a(0)), LW'(32'h0000_07F0));
    chk("t2_evict_data", obs_w(0), 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    chk("t2_fill_addr", LW'(obs_a(1)), LW'(32'h0000_0040));
    r_ev = 1'b0;

    // D and I together from reset: D first, then I, twice
    do_reset();
    wait_cfg = 0; r_dc_addr = 32'h0000_0100; r_ic_addr = 32'h0000_0200;
    r_d_fill = {4{32'hD0D0_0001}}; r_i_fill = {4{32'h1C1C_0001}};
    raise(0, 1, 1);
    run(40);
    chk("t3_first_d", LW'(obs_a(0)), LW'(32'h0000_0100));
    chk("t3_then_i", LW'(obs_a(1)), LW'(32'h0000_0200));
    chk("t3_i_ack_latency", LW'(i_ack_cyc - n_raise), LW'(5));
    r_d_fill = {4{32'hD0D0_0002}}; r_i_fill = {4{32'h1C1C_0002}};
    raise(0, 1, 1);
    run(40);
    chk("t3r_first_d", LW'(obs_a(0)), LW'(32'h0000_0100));
    chk("t3r_then_i", LW'(obs_a(1)), LW'(32'h0000_0200));

    // IO read alongside a D miss: IO first
    wait_cfg = 1; r_io_rw = 1'b0; r_io_addr = 32'hFFFF_0004; r_io_rdata = 32'hCAFE_F00D;
    r_dc_addr = 32'h0000_0300; r_d_fill = {4{32'h3300_0003}};
    raise(1, 1, 0);
    run(40);
    chk("t4_io_first", LW'(obs_a(0)), LW'(32'hFFFF_0004));
    chk("t4_io_rd", LW'(cap_io_rd), LW'(32'hCAFE_F00D));
    chk("t4_io_latency", LW'(io_ack_cyc - n_raise), LW'(3));
    chk("t4_then_d", LW'(obs_a(1)), LW'(32'h0000_0300));

    // IO write: zero-extended data, read data register untouched
    wait_cfg = 0; r_io_rw = 1'b1; r_io_addr = 32'hFFFF_0008; r_io_wdata = 32'h1234_5678;
    r_io_rdata = 32'hBAD0_BAD0;
    raise(1, 0, 0);
    run(40);
    chk("t5_wdata", obs_w(0), 128'h0000_0000_0000_0000_0000_0000_1234_5678);
    chk("t5_io_ack_latency", LW'(io_ack_cyc - n_raise), LW'(2));
    chk("t5_rd_held", LW'(io_rd_data), LW'(32'hCAFE_F00D));

    // Reset during FILL_D before bus_ack, then a stray bus_ack
    wait_cfg = 10; r_dc_addr = 32'h0000_0500; r_d_fill = {4{32'h0500_0500}};
    raise(0, 1, 0);
    tick(); tick(); tick();
    acks0 = ack_count;
    rst_n = 1'b0; dc_miss = 1'b0;
    model_reset();
    tick();
    chk("t6_req_dropped", LW'(bus_req), LW'(0));
    rst_n = 1'b1;
    tick();
    bus_ack = 1'b1; bus_rd_data = {4{32'h7777_7777}};
    tick(); tick(); tick();
    chk("t6_no_ack", LW'(ack_count - acks0), LW'(0));
    wait_cfg = 0; r_dc_addr = 32'h0000_0600; r_d_fill = {4{32'h0600_0600}};
    raise(0, 1, 0);
    run(40);
    chk("t6_next_fill", cap_d_fill, {4{32'h0600_0600}});
    chk("t6_next_latency", LW'(d_ack_cyc - n_raise), LW'(2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
